square_rebuild: RTL and testbench

SQUARE_REBUILD -- requirements
Module: square_rebuild

---
 rtl/sqrt_pkg.sv | 17 +
 rtl/Register.sv | 24 ++
 rtl/square_rebuild_step.sv | 19 +
 rtl/square_rebuild.sv | 127 ++++++++++++
 tb/tb_square_rebuild.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the square-root reconstruction datapath.
package sqrt_pkg;

  typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;

  localparam int DEFAULT_WORD_LENGTH = 16;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/Register.sv
// Generic enabled register with synchronous active-high reset.
module Register #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_enable) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/square_rebuild_step.sv
// One shift-and-add multiply step: adds (multiplicand << bitIndex) when the bit is set.
module shift_add_step #(
  parameter int WORD_LENGTH = 16,
  parameter int N           = WORD_LENGTH / 2,
  parameter int CW          = 3
) (
  input  logic [WORD_LENGTH-1:0] i_acc,
  input  logic [N-1:0]           i_multiplicand,
  input  logic [CW-1:0]          i_bitIndex,
  input  logic                   i_bit,
  output logic [WORD_LENGTH-1:0] o_nextAcc
);

  logic [WORD_LENGTH-1:0] w_shifted;

  assign w_shifted = WORD_LENGTH'(i_multiplicand) << i_bitIndex;
  assign o_nextAcc = i_bit ? (i_acc + w_shifted) : i_acc;

endmodule

// File: rtl/square_rebuild.sv
// Rebuilds radicand = root*root + residue with a serial shift-add multiplier,
// flagging overflow and whether (root, residue) is a legal square-root pair.
module square_rebuild
  import sqrt_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WORD_LENGTH/2-1:0] root,
  input  logic [WORD_LENGTH-1:0]   residue,
  output logic [WORD_LENGTH-1:0]   radicand,
  output logic                     overflow,
  output logic                     consistent,
  output logic                     busy,
  output logic                     done
);

  localparam int N  = WORD_LENGTH / 2;
  localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

  state_t                 r_state;
  logic [N-1:0]           r_root;
  logic [WORD_LENGTH-1:0] r_residue;
  logic                   r_consistent;
  logic [WORD_LENGTH-1:0] r_acc;
  logic [CW-1:0]          r_count;
  logic                   r_busy;
  logic                   r_done;

  logic [WORD_LENGTH-1:0] w_nextAcc;
  logic [WORD_LENGTH:0]   w_sum;
  logic [N:0]             w_twoRoot;
  logic                   w_consistentIn;
  logic                   w_addStrobe;

  // Compare at a width wide enough that neither 2*root nor residue is truncated.
  assign w_twoRoot      = {root, 1'b0};
  assign w_consistentIn = ({1'b0, residue} <= (WORD_LENGTH + 1)'(w_twoRoot));

  assign w_sum       = {1'b0, r_acc} + {1'b0, r_residue};
  assign w_addStrobe = (r_state == ADD);

  shift_add_step #(
    .WORD_LENGTH (WORD_LENGTH),
    .N           (N),
    .CW          (CW)
  ) u_step (
    .i_acc          (r_acc),
    .i_multiplicand (r_root),
    .i_bitIndex     (r_count),
    .i_bit          (r_root[r_count]),
    .o_nextAcc      (w_nextAcc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_root       <= '0;
      r_residue    <= '0;
      r_consistent <= 1'b0;
      r_acc        <= '0;
      r_count      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_root       <= root;
            r_residue    <= residue;
            r_consistent <= w_consistentIn;
            r_acc        <= '0;
            r_count      <= '0;
            r_busy       <= 1'b1;
            r_state      <= MUL;
          end
        end
        MUL: begin
          r_acc <= w_nextAcc;
          if (r_count == CW'(N - 1)) begin
            r_state <= ADD;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        ADD: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Result registers only load on the ADD edge, so they stay stable while MUL runs.
  Register #(.WIDTH(WORD_LENGTH)) u_radicandReg (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_addStrobe),
    .i_d      (w_sum[WORD_LENGTH-1:0]),
    .o_q      (radicand)
  );

  Register #(.WIDTH(1)) u_overflowReg (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_addStrobe),
    .i_d      (w_sum[WORD_LENGTH]),
    .o_q      (overflow)
  );

  Register #(.WIDTH(1)) u_consistentReg (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_addStrobe),
    .i_d      (r_consistent),
    .o_q      (consistent)
  );

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_square_rebuild.sv
// Randomized self-checking bench for square_rebuild against an arithmetic reference model.
module tb_square_rebuild;

  localparam int W = 16;
  localparam int N = W / 2;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] root;
  logic [W-1:0] residue;
  logic [W-1:0] radicand;
  logic         overflow;
  logic         consistent;
  logic         busy;
  logic         done;

  int vectors;
  int miscompares;

  square_rebuild #(.WORD_LENGTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .root       (root),
    .residue    (residue),
    .radicand   (radicand),
    .overflow   (overflow),
    .consistent (consistent),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {radicand, overflow, consistent} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [N-1:0] r, input logic [W-1:0] res);
    longint full;
    logic [W-1:0] rad;
    logic ov, cons;
    full = longint'(r) * longint'(r) + longint'(res);
    rad  = W'(full % 65536);
    ov   = (full > 65535);
    cons = (longint'(res) <= 2 * longint'(r));
    return {rad, ov, cons};
  endfunction

  function automatic int isqrt(input int x);
    int s;
    s = 0;
    while ((s + 1) * (s + 1) <= x) s++;
    return s;
  endfunction

  // Runs one operation; when chained, start is raised in the current (done) cycle.
  task automatic doOp(input logic [N-1:0] r, input logic [W-1:0] res, input bit chained,
                      input int injectAt, output logic [W+1:0] got, output int lat,
                      output bit busyBad, output bit holdBad);
    logic [W+1:0] prevOut;
    if (!chained) @(negedge clk);
    start = 1'b1; root = r; residue = res;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; root = N'($urandom); residue = W'($urandom);
    prevOut = {radicand, overflow, consistent};
    busyBad = (busy !== 1'b1);
    holdBad = 1'b0;
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      if (e == injectAt) begin
        start = 1'b1; root = 8'h01;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        lat = e;
        if (busy !== 1'b0) busyBad = 1'b1;
        break;
      end
      if (busy !== 1'b1) busyBad = 1'b1;
      if ({radicand, overflow, consistent} !== prevOut) holdBad = 1'b1;
    end
    got = {radicand, overflow, consistent};
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; root = 8'hFF; residue = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({radicand, overflow, consistent, busy, done} !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %h expected 0", {radicand, overflow, consistent, busy, done});
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: busy/done got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_vectors;
    logic [N-1:0] rs [3] = '{8'h0C, 8'hFF, 8'hFF};
    logic [W-1:0] es [3] = '{16'h0005, 16'h01FE, 16'h01FF};
    logic [W+1:0] ex [3] = '{{16'h0095, 2'b01}, {16'hFFFF, 2'b01}, {16'h0000, 2'b10}};
    logic [W+1:0] got;
    int lat;
    bit bb, hb;
    for (int i = 0; i < 3; i++) begin
      doOp(rs[i], es[i], 1'b0, 0, got, lat, bb, hb);
      vectors += 3;
      if (got !== ex[i]) begin
        miscompares++;
        $display("[TB] FAIL vector%0d_result: got %h expected %h", i, got, ex[i]);
      end
      if (lat !== 9) begin
        miscompares++;
        $display("[TB] FAIL vector%0d_latency: got %0d expected 9", i, lat);
      end
      if (bb || hb) begin
        miscompares++;
        $display("[TB] FAIL vector%0d_busy_hold: busyBad %0d holdBad %0d expected 0 0", i, bb, hb);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W+1:0] got;
    int lat;
    bit bb, hb;
    doOp(8'h00, 16'h0000, 1'b0, 0, got, lat, bb, hb);
    vectors += 2;
    if (got !== {16'h0000, 2'b01} || lat !== 9) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got %h lat %0d expected %h lat 9", got, lat, {16'h0000, 2'b01});
    end
    if (bb || hb) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_busy_hold: got %0d%0d expected 00", bb, hb);
    end
    doOp(8'h03, 16'h0002, 1'b1, 0, got, lat, bb, hb);
    vectors += 2;
    if (got !== {16'h000B, 2'b01} || lat !== 9) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got %h lat %0d expected %h lat 9", got, lat, {16'h000B, 2'b01});
    end
    if (bb || hb) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_busy_hold: got %0d%0d expected 00", bb, hb);
    end
  endtask

  task automatic test_ignore_start;
    logic [W+1:0] got;
    int lat;
    bit bb, hb;
    doOp(8'h10, 16'h0000, 1'b0, 3, got, lat, bb, hb);
    vectors += 3;
    if (got !== {16'h0100, 2'b01} || lat !== 9) begin
      miscompares++;
      $display("[TB] FAIL ignore_result: got %h lat %0d expected %h lat 9", got, lat, {16'h0100, 2'b01});
    end
    if (bb) begin
      miscompares++;
      $display("[TB] FAIL ignore_busy: busyBad got %0d expected 0", bb);
    end
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignore_single_done: done/busy got %b%b expected 00", done, busy);
    end
  endtask

  task automatic test_reset_midop;
    logic [W+1:0] got;
    int lat;
    bit bb, hb, sawDone;
    @(negedge clk);
    start = 1'b1; root = 8'hAB; residue = 16'h0042;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({radicand, overflow, consistent, busy, done} !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL midop_reset_outputs: got %h expected 0", {radicand, overflow, consistent, busy, done});
    end
    reset = 1'b0;
    sawDone = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) sawDone = 1'b1;
    end
    vectors++;
    if (sawDone) begin
      miscompares++;
      $display("[TB] FAIL midop_discarded: activity after reset got 1 expected 0");
    end
    doOp(8'h05, 16'h0003, 1'b0, 0, got, lat, bb, hb);
    vectors++;
    if (got !== {16'h001C, 2'b01} || lat !== 9) begin
      miscompares++;
      $display("[TB] FAIL midop_fresh: got %h lat %0d expected %h lat 9", got, lat, {16'h001C, 2'b01});
    end
  endtask

  task automatic test_random;
    logic [W+1:0] got, exp;
    logic [N-1:0] r;
    logic [W-1:0] res;
    int lat, x, s;
    bit bb, hb;
    for (int i = 0; i < 1300; i++) begin
      if (i < 1000) begin
        x   = int'($urandom_range(0, 65535));
        s   = isqrt(x);
        r   = N'(s);
        res = W'(x - s * s);
        exp = {W'(x), 2'b01};
      end else begin
        r   = N'($urandom);
        res = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 600));
        exp = model(r, res);
      end
      doOp(r, res, 1'b0, 0, got, lat, bb, hb);
      vectors++;
      if (got !== exp || lat !== 9 || bb || hb) begin
        miscompares++;
        $display("[TB] FAIL random%0d root=%h res=%h: got %h lat %0d bb %0d hb %0d expected %h lat 9",
                 i, r, res, got, lat, bb, hb, exp);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; start = 1'b0; root = '0; residue = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_ignore_start();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
